operand_stream_buffer: RTL and testbench

- Parametrised, double-buffered operand register for the systolic matrix multiplier.
- One bank (shadow) is loaded over the APB-style write path while the other bank (active) streams a diagonally skewed feed into the array.
- A single parameter selects A-side (row skew) or B-side (column skew) feeding, so one block serves both operand positions.
- An internal counter and FSM generate the skew; no external counter is needed.

---
 rtl/operand_stream_buffer.sv | 164 ++++++++++++++++
 tb/tb_operand_stream_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stream_buffer.sv
// operand_stream_buffer: double-buffered operand register for the systolic array.
// The shadow bank is written over the APB-style path while the active bank
// streams a diagonally skewed feed (row skew for A, column skew for B).
// Optional macro OPBUF_CLEAR_ON_SWAP_EN: clear the outgoing active bank on swap.
module operand_stream_buffer #(
   parameter int unsigned BUS_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned OPERAND_SIDE = 1,
   localparam int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
   localparam int unsigned DW          = $clog2(MAX_DIM),
   localparam int unsigned CW          = $clog2(3*MAX_DIM-2)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [BUS_WIDTH-1:0] pwdata_i,
   input  logic [DW-1:0]        addr_Mat_i,
   input  logic                 write_en_Mat_i,
   input  logic [MAX_DIM-1:0]   pstrb_i,
   input  logic [DW-1:0]        dim_rows_i,
   input  logic [DW-1:0]        dim_cols_i,
   input  logic                 start_i,
   output logic [BUS_WIDTH-1:0] read_data_Mat_o,
   output logic [BUS_WIDTH-1:0] feed_o,
   output logic                 feed_valid_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ovr_o
);

   localparam int unsigned LAST = 3*MAX_DIM - 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 start_accept;
   logic                 shadow_sel_q;
   logic                 act_sel;
   logic [CW-1:0]        cnt_q;
   logic [DW-1:0]        rows_lat_q, cols_lat_q;
   logic                 ovr_q;
   logic [BUS_WIDTH-1:0] wr_data;
   logic [BUS_WIDTH-1:0] feed_c;
   logic [BUS_WIDTH-1:0] bank_q [2][MAX_DIM];

   assign act_sel = ~shadow_sel_q;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a start is taken only when not already streaming
   always_comb begin
      state_d      = state_q;
      start_accept = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               start_accept = 1'b1;
               state_d      = STREAM;
            end
         end
         STREAM: begin
            if (cnt_q == CW'(LAST)) state_d = DONE;
         end
         DONE: begin
            if (start_i) begin
               start_accept = 1'b1;
               state_d      = STREAM;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bank select, skew counter, latched dims and sticky overrun flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_sel_q <= 1'b0;
         cnt_q        <= '0;
         rows_lat_q   <= '0;
         cols_lat_q   <= '0;
         ovr_q        <= 1'b0;
      end else begin
         if (start_accept) begin
            shadow_sel_q <= ~shadow_sel_q;
            cnt_q        <= '0;
            rows_lat_q   <= dim_rows_i;
            cols_lat_q   <= dim_cols_i;
         end else if (state_q == STREAM) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if ((state_q == STREAM) && start_i) ovr_q <= 1'b1;
      end
   end

   // Write data with elements outside the current dims forced to zero
   always_comb begin
      wr_data = '0;
      for (int c = 0; c < MAX_DIM; c++) begin
         if ((addr_Mat_i <= dim_rows_i) && (DW'(c) <= dim_cols_i))
            wr_data[c*DATA_WIDTH +: DATA_WIDTH] = pwdata_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Bank storage: strobed writes into the shadow bank
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < MAX_DIM; r++)
               bank_q[b][r] <= '0;
      end else begin
`ifdef OPBUF_CLEAR_ON_SWAP_EN
         if (start_accept)
            for (int r = 0; r < MAX_DIM; r++)
               bank_q[act_sel][r] <= '0;
`endif
         if (write_en_Mat_i)
            for (int c = 0; c < MAX_DIM; c++)
               if (pstrb_i[c])
                  bank_q[shadow_sel_q][addr_Mat_i][c*DATA_WIDTH +: DATA_WIDTH]
                     <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Skewed feed: lane r carries element index e = t - r of its row/column
   for (genvar r = 0; r < MAX_DIM; r++) begin : g_lane
      logic [CW:0]   e;
      logic [DW-1:0] e_idx;
      logic          in_win;
      logic          in_dims;

      assign e      = {1'b0, cnt_q} - (CW+1)'(r);
      assign e_idx  = e[DW-1:0];
      assign in_win = !e[CW] && (e < (CW+1)'(MAX_DIM));

      if (OPERAND_SIDE == 1) begin : g_side_b
         assign in_dims = (e <= (CW+1)'(rows_lat_q)) && (DW'(r) <= cols_lat_q);
         assign feed_c[r*DATA_WIDTH +: DATA_WIDTH] =
            ((state_q == STREAM) && in_win && in_dims)
               ? bank_q[act_sel][e_idx][r*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_side_a
         assign in_dims = (DW'(r) <= rows_lat_q) && (e <= (CW+1)'(cols_lat_q));
         assign feed_c[r*DATA_WIDTH +: DATA_WIDTH] =
            ((state_q == STREAM) && in_win && in_dims)
               ? bank_q[act_sel][r][e_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
   end

   assign feed_o          = feed_c;
   assign feed_valid_o    = (state_q == STREAM);
   assign busy_o          = (state_q == STREAM);
   assign done_o          = (state_q == DONE);
   assign ovr_o           = ovr_q;
   assign read_data_Mat_o = rst_i ? '0 : bank_q[shadow_sel_q][addr_Mat_i];

endmodule

// File: tb/tb_operand_stream_buffer.sv
// Bench for operand_stream_buffer: A-side and B-side instances share stimulus;
// expected feed beats are queued at each accepted start and popped per beat.
module tb_operand_stream_buffer;

   localparam int unsigned BW    = 32;
   localparam int unsigned MD    = 4;
   localparam int          BEATS = 3*MD - 2;

   localparam logic [BW-1:0] M1 [MD] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
   localparam logic [BW-1:0] MX [MD] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};
   localparam logic [BW-1:0] MY [MD] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF01};
   localparam logic [BW-1:0] M2 [MD] = '{32'h00030201, 32'h00070605, 32'h00000000, 32'h00000000};

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] pwdata;
   logic [1:0]    addr;
   logic          wen;
   logic [MD-1:0] pstrb;
   logic [1:0]    dim_rows, dim_cols;
   logic          start;
   logic [BW-1:0] rd_b, rd_a, feed_b, feed_a;
   logic          fv_b, fv_a, busy_b, busy_a, done_b, done_a, ovr_b, ovr_a;

   logic [BW-1:0] mdl_bank [2][MD];
   logic          mdl_sel;
   logic [BW-1:0] q_b [$];
   logic [BW-1:0] q_a [$];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   operand_stream_buffer #(.BUS_WIDTH(32), .DATA_WIDTH(8), .OPERAND_SIDE(1)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .pwdata_i(pwdata), .addr_Mat_i(addr),
      .write_en_Mat_i(wen), .pstrb_i(pstrb), .dim_rows_i(dim_rows), .dim_cols_i(dim_cols),
      .start_i(start), .read_data_Mat_o(rd_b), .feed_o(feed_b), .feed_valid_o(fv_b),
      .busy_o(busy_b), .done_o(done_b), .ovr_o(ovr_b));

   operand_stream_buffer #(.BUS_WIDTH(32), .DATA_WIDTH(8), .OPERAND_SIDE(0)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .pwdata_i(pwdata), .addr_Mat_i(addr),
      .write_en_Mat_i(wen), .pstrb_i(pstrb), .dim_rows_i(dim_rows), .dim_cols_i(dim_cols),
      .start_i(start), .read_data_Mat_o(rd_a), .feed_o(feed_a), .feed_valid_o(fv_a),
      .busy_o(busy_a), .done_o(done_a), .ovr_o(ovr_a));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < MD; r++)
            mdl_bank[b][r] = '0;
      mdl_sel = 1'b0;
      q_b.delete();
      q_a.delete();
   endtask

   // Reference write: zero elements outside the dims currently on the inputs
   task automatic model_write(input logic [1:0] a, input logic [BW-1:0] d, input logic [MD-1:0] s);
      for (int c = 0; c < MD; c++)
         if (s[c])
            mdl_bank[mdl_sel][a][c*8 +: 8] =
               (c > int'(dim_cols) || int'(a) > int'(dim_rows)) ? 8'h00 : d[c*8 +: 8];
   endtask

   // Reference swap: queue every beat of the stream for both operand sides
   task automatic model_start();
      logic          act;
      int            e;
      logic [BW-1:0] fb, fa;
      act = mdl_sel;
`ifdef OPBUF_CLEAR_ON_SWAP_EN
      for (int r = 0; r < MD; r++) mdl_bank[~mdl_sel][r] = '0;
`endif
      mdl_sel = ~mdl_sel;
      for (int t = 0; t < BEATS; t++) begin
         fb = '0;
         fa = '0;
         for (int r = 0; r < MD; r++) begin
            e = t - r;
            if (e >= 0 && e < MD) begin
               if (e <= int'(dim_rows) && r <= int'(dim_cols)) fb[r*8 +: 8] = mdl_bank[act][e][r*8 +: 8];
               if (r <= int'(dim_rows) && e <= int'(dim_cols)) fa[r*8 +: 8] = mdl_bank[act][r][e*8 +: 8];
            end
         end
         q_b.push_back(fb);
         q_a.push_back(fa);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [BW-1:0] d, input logic [MD-1:0] s);
      addr = a; pwdata = d; pstrb = s; wen = 1'b1;
      model_write(a, d, s);
      tick();
      wen = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wen = 1'b0; start = 1'b0; pwdata = '0; addr = '0; pstrb = '0;
      dim_rows = 2'd3; dim_cols = 2'd3;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({feed_b, feed_a} !== 64'h0) begin n_err++; $display("FAIL reset_feed: got %h/%h want 0", feed_b, feed_a); end
      n_cmp++; if ({fv_b, fv_a, busy_b, busy_a, done_b, done_a, ovr_b, ovr_a} !== 8'h00) begin n_err++;
         $display("FAIL reset_flags: got %b want 00000000", {fv_b, fv_a, busy_b, busy_a, done_b, done_a, ovr_b, ovr_a}); end
      n_cmp++; if ({rd_b, rd_a} !== 64'h0) begin n_err++; $display("FAIL reset_read: got %h/%h want 0", rd_b, rd_a); end
      rst = 1'b0;
      tick();
      @(negedge clk);
      n_cmp++; if ({fv_b, busy_b, done_b, ovr_b, rd_b} !== 36'h0) begin n_err++;
         $display("FAIL post_reset_idle: got fv=%b busy=%b done=%b ovr=%b rd=%h want all 0", fv_b, busy_b, done_b, ovr_b, rd_b); end
      tick();
   endtask

   task automatic test_skew();
      logic [BW-1:0] eb, ea;
      dim_rows = 2'd3; dim_cols = 2'd3;
      for (int r = 0; r < MD; r++) wr(2'(r), M1[r], 4'hF);
      addr = 2'd2;
      @(negedge clk);
      n_cmp++; if (rd_b !== 32'h0C0B0A09 || rd_a !== 32'h0C0B0A09) begin n_err++;
         $display("FAIL skew_read_row2: got %h/%h want 0c0b0a09", rd_b, rd_a); end
      tick();
      start = 1'b1; model_start(); tick(); start = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         n_cmp++; if (fv_b !== 1'b1 || fv_a !== 1'b1 || busy_b !== 1'b1 || done_b !== 1'b0) begin n_err++;
            $display("FAIL skew_valid beat %0d: got fv=%b/%b busy=%b done=%b want 1/1/1/0", k, fv_b, fv_a, busy_b, done_b); end
         eb = q_b.pop_front(); ea = q_a.pop_front();
         n_cmp++; if (feed_b !== eb) begin n_err++; $display("FAIL skew_b beat %0d: got %h want %h", k, feed_b, eb); end
         n_cmp++; if (feed_a !== ea) begin n_err++; $display("FAIL skew_a beat %0d: got %h want %h", k, feed_a, ea); end
         if (k == 0) begin n_cmp++; if (feed_b !== 32'h00000001) begin n_err++; $display("FAIL skew_beat0: got %h want 00000001", feed_b); end end
         if (k == 3) begin n_cmp++; if (feed_b !== 32'h04070A0D) begin n_err++; $display("FAIL skew_beat3: got %h want 04070a0d", feed_b); end end
         if (k == BEATS-1) begin n_cmp++; if (feed_b !== 32'h0) begin n_err++; $display("FAIL skew_beat9: got %h want 0", feed_b); end end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (done_b !== 1'b1 || done_a !== 1'b1 || fv_b !== 1'b0 || busy_b !== 1'b0 || feed_b !== 32'h0) begin n_err++;
         $display("FAIL skew_done: got done=%b/%b fv=%b busy=%b feed=%h want 1/1/0/0/0", done_b, done_a, fv_b, busy_b, feed_b); end
      tick();
      @(negedge clk);
      n_cmp++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin n_err++; $display("FAIL skew_idle: got done=%b busy=%b want 0/0", done_b, busy_b); end
      tick();
   endtask

   task automatic test_dims_a();
      logic [BW-1:0] eb, ea;
      dim_rows = 2'd1; dim_cols = 2'd2;
      for (int r = 0; r < MD; r++) wr(2'(r), M1[r], 4'hF);
      for (int r = 0; r < MD; r++) begin
         addr = 2'(r);
         @(negedge clk);
         n_cmp++; if (rd_a !== M2[r]) begin n_err++; $display("FAIL dims_read row %0d: got %h want %h", r, rd_a, M2[r]); end
         tick();
      end
      start = 1'b1; model_start(); tick(); start = 1'b0;
      dim_rows = 2'd3; dim_cols = 2'd3;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         eb = q_b.pop_front(); ea = q_a.pop_front();
         n_cmp++; if (feed_a !== ea) begin n_err++; $display("FAIL dims_a beat %0d: got %h want %h", k, feed_a, ea); end
         n_cmp++; if (feed_b !== eb) begin n_err++; $display("FAIL dims_b beat %0d: got %h want %h", k, feed_b, eb); end
         n_cmp++; if (feed_a[31:24] !== 8'h00) begin n_err++; $display("FAIL dims_lane3 beat %0d: got %h want 00", k, feed_a[31:24]); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (done_a !== 1'b1) begin n_err++; $display("FAIL dims_done: got %b want 1", done_a); end
      tick();
      tick();
   endtask

   task automatic test_strobe();
      dim_rows = 2'd3; dim_cols = 2'd3;
      wr(2'd1, 32'h08070605, 4'hF);
      wr(2'd1, 32'hAABBCCDD, 4'h5);
      addr = 2'd1;
      @(negedge clk);
      n_cmp++; if (rd_b !== 32'h08BB06DD || rd_a !== 32'h08BB06DD) begin n_err++;
         $display("FAIL strobe_0x5: got %h/%h want 08bb06dd", rd_b, rd_a); end
      tick();
      wr(2'd1, 32'hFFFFFFFF, 4'h0);
      @(negedge clk);
      n_cmp++; if (rd_b !== 32'h08BB06DD) begin n_err++; $display("FAIL strobe_none: got %h want 08bb06dd", rd_b); end
      tick();
   endtask

   task automatic test_write_during_stream();
      logic [BW-1:0] eb, ea;
      dim_rows = 2'd3; dim_cols = 2'd3;
      for (int r = 0; r < MD; r++) wr(2'(r), MX[r], 4'hF);
      start = 1'b1; model_start(); tick(); start = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         eb = q_b.pop_front(); ea = q_a.pop_front();
         n_cmp++; if (feed_b !== eb) begin n_err++; $display("FAIL wds_b beat %0d: got %h want %h", k, feed_b, eb); end
         n_cmp++; if (feed_a !== ea) begin n_err++; $display("FAIL wds_a beat %0d: got %h want %h", k, feed_a, ea); end
         if (k == 2) begin n_cmp++; if (ovr_b !== 1'b0) begin n_err++; $display("FAIL wds_ovr_early: got %b want 0", ovr_b); end end
         if (k == 7) begin
            n_cmp++; if (ovr_b !== 1'b1 || ovr_a !== 1'b1) begin n_err++; $display("FAIL wds_ovr_set: got %b/%b want 1", ovr_b, ovr_a); end
            n_cmp++; if (rd_b !== MY[2]) begin n_err++; $display("FAIL wds_read_new: got %h want %h", rd_b, MY[2]); end
         end
         tick();
         wen = 1'b0; start = 1'b0;
         if (k < MD) begin
            addr = 2'(k); pwdata = MY[k]; pstrb = 4'hF; wen = 1'b1;
            model_write(2'(k), MY[k], 4'hF);
         end
         if (k == 5) start = 1'b1;
         if (k == 6) addr = 2'd2;
      end
      @(negedge clk);
      n_cmp++; if (done_b !== 1'b1 || ovr_b !== 1'b1) begin n_err++; $display("FAIL wds_done_ovr: got done=%b ovr=%b want 1/1", done_b, ovr_b); end
      start = 1'b1; model_start(); tick(); start = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         eb = q_b.pop_front(); ea = q_a.pop_front();
         n_cmp++; if (fv_b !== 1'b1) begin n_err++; $display("FAIL b2b_valid beat %0d: got %b want 1", k, fv_b); end
         n_cmp++; if (feed_b !== eb) begin n_err++; $display("FAIL b2b_b beat %0d: got %h want %h", k, feed_b, eb); end
         n_cmp++; if (feed_a !== ea) begin n_err++; $display("FAIL b2b_a beat %0d: got %h want %h", k, feed_a, ea); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (done_b !== 1'b1 || ovr_b !== 1'b1) begin n_err++; $display("FAIL b2b_done_ovr: got done=%b ovr=%b want 1/1", done_b, ovr_b); end
      tick();
   endtask

   task automatic test_reset_midstream();
      logic [BW-1:0] eb, ea;
      dim_rows = 2'd3; dim_cols = 2'd3;
      for (int r = 0; r < MD; r++) wr(2'(r), M1[r], 4'hF);
      start = 1'b1; model_start(); tick(); start = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         eb = q_b.pop_front(); ea = q_a.pop_front();
         n_cmp++; if (feed_b !== eb) begin n_err++; $display("FAIL rms_b beat %0d: got %h want %h", k, feed_b, eb); end
         n_cmp++; if (feed_a !== ea) begin n_err++; $display("FAIL rms_a beat %0d: got %h want %h", k, feed_a, ea); end
         if (k < 4) tick();
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({feed_b, feed_a} !== 64'h0) begin n_err++; $display("FAIL rms_feed: got %h/%h want 0", feed_b, feed_a); end
      n_cmp++; if ({fv_b, fv_a, busy_b, busy_a, ovr_b, ovr_a} !== 6'h0) begin n_err++;
         $display("FAIL rms_flags: got %b want 000000", {fv_b, fv_a, busy_b, busy_a, ovr_b, ovr_a}); end
      for (int r = 0; r < MD; r++) begin
         addr = 2'(r);
         #1;
         n_cmp++; if (rd_b !== 32'h0 || rd_a !== 32'h0) begin n_err++; $display("FAIL rms_read row %0d: got %h/%h want 0", r, rd_b, rd_a); end
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      tick();
      for (int r = 0; r < MD; r++) begin
         addr = 2'(r);
         @(negedge clk);
         n_cmp++; if (rd_b !== 32'h0 || busy_b !== 1'b0) begin n_err++; $display("FAIL rms_after row %0d: got rd=%h busy=%b want 0/0", r, rd_b, busy_b); end
         tick();
      end
   endtask

   task automatic test_swap_clear();
      logic [BW-1:0] eb, ea, exp_rd;
      dim_rows = 2'd3; dim_cols = 2'd3;
      for (int r = 0; r < MD; r++) wr(2'(r), MY[r], 4'hF);
      start = 1'b1; model_start(); tick(); start = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         eb = q_b.pop_front(); ea = q_a.pop_front();
         n_cmp++; if (feed_b !== eb) begin n_err++; $display("FAIL swap1_b beat %0d: got %h want %h", k, feed_b, eb); end
         n_cmp++; if (feed_a !== ea) begin n_err++; $display("FAIL swap1_a beat %0d: got %h want %h", k, feed_a, ea); end
         tick();
      end
      tick();
      for (int r = 0; r < MD; r++) wr(2'(r), MX[r], 4'hF);
      start = 1'b1; model_start(); tick(); start = 1'b0;
      addr = 2'd0;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         eb = q_b.pop_front(); ea = q_a.pop_front();
         n_cmp++; if (feed_b !== eb) begin n_err++; $display("FAIL swap2_b beat %0d: got %h want %h", k, feed_b, eb); end
         n_cmp++; if (feed_a !== ea) begin n_err++; $display("FAIL swap2_a beat %0d: got %h want %h", k, feed_a, ea); end
         if (k < MD) begin
`ifdef OPBUF_CLEAR_ON_SWAP_EN
            exp_rd = '0;
`else
            exp_rd = MY[k];
`endif
            n_cmp++; if (rd_b !== exp_rd || rd_a !== exp_rd) begin n_err++;
               $display("FAIL swap_read row %0d: got %h/%h want %h", k, rd_b, rd_a, exp_rd); end
         end
         tick();
         if (k < MD-1) addr = 2'(k+1);
      end
      @(negedge clk);
      n_cmp++; if (done_b !== 1'b1) begin n_err++; $display("FAIL swap_done: got %b want 1", done_b); end
      tick();
   endtask

   initial begin
      test_reset();
      test_skew();
      test_dims_a();
      test_strobe();
      test_write_during_stream();
      test_reset_midstream();
      test_swap_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
